// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stall, taken-branch flush,
// data-memory wait with timeout halt, and stall/flush performance counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_r;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;
   logic       load_use;
   logic       mem_block;
   logic       run_stall;
   logic       timeout_set;
   logic       stall_inc;
   logic       flush_inc;

   assign load_use  = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign mem_block = dmem_req && !dmem_ready;
   // A taken branch flushes the dependent instruction anyway, so it masks load-use.
   assign run_stall = load_use && !ex_branch_taken;
   assign state     = state_r;
   assign stall_inc = (state_r != HALT) && !pc_write;

   always_comb begin
      state_nxt    = state_r;
      wait_cnt_nxt = wait_cnt;
      timeout_set  = 1'b0;
      flush_inc    = 1'b0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      if (!rst) begin
         case (state_r)
            RUN, MEM_WAIT: begin
               if ((state_r == RUN) ? mem_block : !dmem_ready) begin
                  if (state_r == RUN) begin
                     state_nxt    = MEM_WAIT;
                     wait_cnt_nxt = 8'd1;
                  end else begin
                     wait_cnt_nxt = wait_cnt + 8'd1;
                     if (wait_cnt == TIMEOUT_C) begin
                        state_nxt   = HALT;
                        timeout_set = 1'b1;
                     end
                  end
               end else begin
                  pc_write    = !run_stall;
                  ifid_write  = !run_stall;
                  idex_write  = 1'b1;
                  exmem_write = 1'b1;
                  ifid_flush  = ex_branch_taken;
                  idex_flush  = ex_branch_taken || run_stall;
                  flush_inc   = ex_branch_taken;
                  state_nxt   = RUN;
               end
            end
            HALT: begin
               state_nxt = HALT;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state_r  <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
         if (stall_inc) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (flush_inc) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end
endmodule
